// File: rtl/drum_sched_pkg.sv
// Shared types and helpers for the DRUM multiplier scheduler.
// Holds the pipeline stage records, the round-robin pick helper and the
// fixed operand/product widths.
package drum_sched_pkg;

  localparam int OPW      = 8;
  localparam int PRODW    = 16;
  localparam int NREQ_MAX = 8;
  localparam int IDW_MAX  = 3;

  // Issue stage: operands waiting for the multiplier
  typedef struct packed {
    logic               v;
    logic [OPW-1:0]     a;
    logic [OPW-1:0]     b;
    logic [IDW_MAX-1:0] id;
    logic               exact;
  } iss_t;

  // Response stage: registered product presented downstream
  typedef struct packed {
    logic               v;
    logic [PRODW-1:0]   prod;
    logic [IDW_MAX-1:0] id;
  } rsp_t;

  typedef struct packed {
    logic               found;
    logic [IDW_MAX-1:0] idx;
  } pick_t;

  // First set bit of valid at or after ptr+1, wrapping modulo nreq.
  // Scanned from the farthest candidate down so the nearest one wins.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                    input logic [IDW_MAX-1:0]  ptr,
                                    input logic [3:0]          nreq);
    pick_t      r;
    logic [3:0] j;
    r = '0;
    for (int k = NREQ_MAX; k >= 1; k--) begin
      if (k[3:0] <= nreq) begin
        j = {1'b0, ptr} + k[3:0];
        if (j >= nreq) j = j - nreq;
        if (valid[j[2:0]]) begin
          r.found = 1'b1;
          r.idx   = j[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/drum_mul_scheduler_if.sv
// Requester and response bus of the DRUM multiplier scheduler.
// Handshake rule (both directions): a beat transfers on the rising edge where
// valid and ready are both high; the source keeps its payload stable while
// valid is high and ready is low, and may drop a request before it is taken.
interface drum_mul_scheduler_if #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_exact;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_prod;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_exact, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_exact, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod, busy
  );
endinterface

// File: rtl/drum_rr_arbiter.sv
// Round-robin arbiter for the issue slot. rr_ptr holds the last granted
// requester; the search starts one past it. The pointer only moves on an
// actual transfer, so an idle or stalled slot does not disturb fairness.
module drum_rr_arbiter
  import drum_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    valid,
  input  logic               adv,
  output logic [NREQ-1:0]    grant,
  output logic [IDW_MAX-1:0] grant_idx,
  output logic               grant_vld
);

  logic [IDW_MAX-1:0]  rr_ptr;
  logic [NREQ_MAX-1:0] valid_w;
  pick_t               pick;

  // Combinational grant; a grant implies the chosen requester is valid
  always_comb begin
    valid_w            = '0;
    valid_w[NREQ-1:0]  = valid;
    pick               = rr_pick(valid_w, rr_ptr, 4'(NREQ));
    grant_vld          = adv & pick.found;
    grant_idx          = pick.idx;
    grant              = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = grant_vld && (pick.idx == IDW_MAX'(i));
    end
  end

  // Pointer follows accepted transfers only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= IDW_MAX'(NREQ - 1);
    end else if (grant_vld) begin
      rr_ptr <= pick.idx;
    end
  end

endmodule

// File: rtl/main_drum.sv
// 8x8 unsigned DRUM approximate multiplier with a 4-bit kept segment.
// Operands below 16 pass through exactly; larger ones keep the 4 bits from the
// leading one down, force the lowest kept bit to 1 (unbiasing) and shift back.
module main_drum
  import drum_sched_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] prod
);

  // Returns {shift[2:0], segment[3:0]}
  function automatic logic [6:0] drum_trunc(input logic [7:0] x);
    logic [2:0] lead;
    logic [2:0] sh;
    logic [7:0] s;
    lead = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) lead = i[2:0];
    end
    if (lead < 3'd4) begin
      drum_trunc = {3'b000, x[3:0]};
    end else begin
      sh = lead - 3'd3;
      s  = x >> sh;
      drum_trunc = {sh, s[3:1], 1'b1};
    end
  endfunction

  logic [6:0]  ta, tb;
  logic [15:0] seg_prod;

  // Multiply the kept segments and restore the dropped magnitude
  always_comb begin
    ta       = drum_trunc(a);
    tb       = drum_trunc(b);
    seg_prod = {12'b0, ta[3:0]} * {12'b0, tb[3:0]};
    prod     = seg_prod << ({1'b0, ta[6:4]} + {1'b0, tb[6:4]});
  end

endmodule

// File: rtl/drum_mul_scheduler.sv
// Shares one DRUM approximate multiplier between NREQ requesters through a
// two-stage pipeline: ISS holds granted operands (feeding the multiplier
// combinationally), RSP holds the registered tagged product.
// Optional feature macro: DRUM_SCHED_EXACT_EN adds an exact 8x8 multiply
// selected per request by req_exact; without it req_exact is ignored.
module drum_mul_scheduler
  import drum_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input logic                clk,
  input logic                rst_n,
  drum_mul_scheduler_if.slave bus
);

  iss_t               iss_q;
  rsp_t               rsp_q;
  logic               adv_rsp;
  logic               adv_iss;
  logic [NREQ-1:0]    grant;
  logic [IDW_MAX-1:0] grant_idx;
  logic               grant_vld;
  logic [OPW-1:0]     sel_a;
  logic [OPW-1:0]     sel_b;
  logic               sel_exact;
  logic [PRODW-1:0]   drum_prod;
  logic [PRODW-1:0]   iss_prod;

  // RSP can take a new value when empty or draining; ISS refills whenever it
  // is empty or moving into RSP. No grants are offered while in reset.
  assign adv_rsp = !rsp_q.v | bus.rsp_ready;
  assign adv_iss = rst_n & (!iss_q.v | adv_rsp);

  drum_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (bus.req_valid),
    .adv       (adv_iss),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign bus.req_ready = grant;

  // Operand select for the granted requester
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_exact = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW_MAX'(i)) begin
        sel_a     = bus.req_a[i*OPW +: OPW];
        sel_b     = bus.req_b[i*OPW +: OPW];
        sel_exact = bus.req_exact[i];
      end
    end
  end

  main_drum u_drum (
    .a    (iss_q.a),
    .b    (iss_q.b),
    .prod (drum_prod)
  );

  // Product for the ISS entry; a zero operand always yields zero
  always_comb begin
    iss_prod = drum_prod;
`ifdef DRUM_SCHED_EXACT_EN
    if (iss_q.exact) iss_prod = {8'b0, iss_q.a} * {8'b0, iss_q.b};
`endif
    if (iss_q.a == '0 || iss_q.b == '0) iss_prod = '0;
  end

  // Pipeline registers: ISS loads on grant, RSP loads from ISS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_q <= '0;
      rsp_q <= '0;
    end else begin
      if (adv_iss) begin
        iss_q.v <= grant_vld;
        if (grant_vld) begin
          iss_q.a  <= sel_a;
          iss_q.b  <= sel_b;
          iss_q.id <= grant_idx;
`ifdef DRUM_SCHED_EXACT_EN
          iss_q.exact <= sel_exact;
`else
          iss_q.exact <= 1'b0;
`endif
        end
      end
      if (adv_rsp) begin
        rsp_q.v <= iss_q.v;
        if (iss_q.v) begin
          rsp_q.prod <= iss_prod;
          rsp_q.id   <= iss_q.id;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_q.v;
  assign bus.rsp_id    = rsp_q.id[ID_W-1:0];
  assign bus.rsp_prod  = rsp_q.prod;
  assign bus.busy      = iss_q.v | rsp_q.v;

endmodule

// File: tb/tb_drum_mul_scheduler.sv
// Bench for drum_mul_scheduler: directed scenarios plus randomized traffic,
// checked by a negedge monitor against an occupancy/round-robin reference
// model and an expected-response queue.
module tb_drum_mul_scheduler;
  import drum_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int W    = ID_W + PRODW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drum_mul_scheduler_if #(.NREQ(NREQ)) bus ();

  drum_mul_scheduler #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0]    exp_q[$];
  int              stamp_q[$];
  int              cyc = 0;
  int              model_ptr = NREQ - 1;
  logic            rst_prev = 1'b1;
  logic [NREQ-1:0] fired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int drum_term(input int x, output int sh);
    int lg;
    sh = 0;
    if (x < 16) return x;
    lg = 0;
    while ((1 << (lg + 1)) <= x) lg++;
    sh = lg - 3;
    return (x / (1 << sh)) | 1;
  endfunction

  function automatic logic [15:0] model_prod(input int a, input int b, input bit ex);
    int ta, tb, sa, sb;
    if (a == 0 || b == 0) return 16'd0;
`ifdef DRUM_SCHED_EXACT_EN
    if (ex) return 16'(a * b);
`endif
    ta = drum_term(a, sa);
    tb = drum_term(b, sb);
    return 16'(ta * tb * (1 << (sa + sb)));
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int              exp_g;
  int              n_before;
  logic            exp_rv;
  logic            can_acc;
  logic [NREQ-1:0] exp_ready;

  // Checks every cycle away from the rising edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      stamp_q.delete();
      model_ptr = NREQ - 1;
      check("ready_in_reset", 32'(bus.req_ready), 32'd0);
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        check("rsp_id_after_reset", 32'(bus.rsp_id), 32'd0);
        check("rsp_prod_after_reset", 32'(bus.rsp_prod), 32'd0);
      end
      rst_prev = 1'b0;
      n_before = exp_q.size();
      exp_rv   = (n_before > 0) && (stamp_q[0] <= cyc - 2);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check("busy", 32'(bus.busy), 32'(n_before > 0));
      if (bus.rsp_valid && exp_rv) begin
        check("rsp_id_prod", 32'({bus.rsp_id, bus.rsp_prod}), 32'(exp_q[0]));
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          void'(stamp_q.pop_front());
        end
      end
      // ISS has room unless two items are in flight and RSP is stuck
      can_acc = (n_before < 2) || bus.rsp_ready;
      exp_g   = -1;
      if (can_acc) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (exp_g < 0 && bus.req_valid[(model_ptr + k) % NREQ])
            exp_g = (model_ptr + k) % NREQ;
        end
      end
      exp_ready = (exp_g >= 0) ? NREQ'(1 << exp_g) : '0;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (exp_g >= 0) begin
        exp_q.push_back({ID_W'(exp_g),
                         model_prod(int'(bus.req_a[exp_g*8 +: 8]),
                                    int'(bus.req_b[exp_g*8 +: 8]),
                                    bus.req_exact[exp_g])});
        stamp_q.push_back(cyc);
        model_ptr = exp_g;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    fired = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic ex);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[i*8 +: 8]    = a;
    bus.req_b[i*8 +: 8]    = b;
    bus.req_exact[i]       = ex;
  endtask

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 8'd0;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic refresh_fired();
    for (int i = 0; i < NREQ; i++)
      if (fired[i]) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_accept(input int i);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!fired[i] && t < 20);
    tests++;
    if (!fired[i]) begin
      fails++;
      $display("FAIL accept_timeout req%0d: no accept within 20 cycles", i);
    end
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && t < 50) begin
      tick();
      t++;
    end
    tests++;
    if (exp_q.size() != 0 || bus.busy) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  task automatic rand_cycles(input int n, input int ready_pct);
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !fired[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) != 0) begin
          set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  // ---------------- stimulus ----------------
  int acc;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_exact = '0;
    bus.rsp_ready = 1'b1;
    fired         = '0;
    rst_n         = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // single request from requester 0
    set_req(0, 8'd200, 8'd100, 1'b0);
    wait_accept(0);
    drain();

    // all requesters valid, full throughput
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'b0);
    repeat (12) begin
      tick();
      refresh_fired();
    end
    drain();

    // downstream stalled for 5 cycles with everyone valid
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'b0);
    bus.rsp_ready = 1'b0;
    acc = 0;
    repeat (5) begin
      tick();
      acc += $countones(fired);
      refresh_fired();
    end
    check("accepts_while_stalled", 32'(acc), 32'd2);
    bus.rsp_ready = 1'b1;
    repeat (6) begin
      tick();
      refresh_fired();
    end
    drain();

    // zero operands
    set_req(0, 8'd0, 8'd255, 1'b0);
    set_req(1, 8'd37, 8'd0, 1'b0);
    wait_accept(0);
    wait_accept(1);
    drain();

    // reset with both stages full, then requester 0 must win first
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'b0);
    bus.rsp_ready = 1'b0;
    repeat (4) begin
      tick();
      refresh_fired();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'b0);
    tick();
    check("first_grant_after_reset", 32'(fired), 32'd1);
    refresh_fired();
    drain();

    // exact-mode operands (ignored unless the exact feature is built in)
    set_req(2, 8'd173, 8'd91, 1'b1);
    wait_accept(2);
    set_req(2, 8'd173, 8'd91, 1'b0);
    wait_accept(2);
    drain();

    // randomized traffic with varying backpressure
    rand_cycles(2000, 70);
    rand_cycles(600, 25);
    rand_cycles(600, 100);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
